// File: rtl/mesa_uart_tx_fifo_phy.sv
// Mesa-Bus transmit PHY: byte FIFO -> optional hex-ASCII expansion -> 8-N-1/8-N-2 UART.
// Define MESA_TX_PARITY_EN to insert an even-parity bit after d[7].
module mesa_uart_tx_fifo_phy #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int BAUD_W          = 16,
    parameter int STOP_BITS       = 1,
    parameter int ASCII_MODE      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BAUD_W-1:0]        baud_rate,
    input  logic                     baud_lock,
    input  logic                     byte_en,
    input  logic [7:0]               byte_d,
    output logic                     byte_busy,
    input  logic                     byte_done,
    output logic                     txd,
    output logic                     tx_idle,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     overflow
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
`ifdef MESA_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int SHIFT_W = 8 + PAR_BITS + STOP_BITS;
    localparam logic [3:0]        SHIFT_CNT = SHIFT_W[3:0];
    localparam logic [LVL_W-1:0]  LVL_FULL  = DEPTH[LVL_W-1:0];
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_CHAR_HI, ST_CHAR_LO, ST_CHAR_EOL} state_t;

    logic [7:0]                 r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LVL_W-1:0]           r_level;
    logic                       r_busy;
    logic                       r_overflow;
    logic                       r_eol;
    state_t                     r_state;
    logic [3:0]                 r_cur_lo;
    logic                       r_ser_busy;
    logic                       r_txd;
    logic [SHIFT_W-1:0]         r_shift;
    logic [3:0]                 r_bits_left;
    logic [BAUD_W-1:0]          r_baud_cnt;
    logic [BAUD_W-1:0]          r_baud_val;

    logic               w_ascii;
    logic               w_wr;
    logic               w_pop;
    logic               w_fifo_empty;
    logic               w_ser_done;
    logic               w_at_idle;
    logic               w_start_byte;
    logic               w_start_eol;
    logic               w_start_lo;
    logic               w_load;
    logic               w_eol_set;
    logic               w_eol_clear;
    logic [7:0]         w_fifo_q;
    logic [7:0]         w_load_char;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [BAUD_W-1:0]  w_baud_eff;
    logic [SHIFT_W-1:0] w_frame_tail;

    // 10..15 map to 'a'..'f': 0x61 - 10 = 0x57.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h57 + {4'h0, n};
    endfunction

    assign w_ascii      = (ASCII_MODE != 0);
    assign w_wr         = byte_en && !r_busy;
    assign w_fifo_empty = (r_level == '0);
    assign w_fifo_q     = r_mem[r_rd_ptr];
    assign w_level_nxt  = r_level + LVL_W'(w_wr) - LVL_W'(w_pop);
    assign w_baud_eff   = (baud_rate == '0) ? BAUD_ONE : baud_rate;

    assign w_ser_done   = r_ser_busy && (r_baud_cnt == BAUD_ONE) && (r_bits_left == 4'd0);
    assign w_eol_set    = byte_done && w_ascii;
    assign w_eol_clear  = (r_state == ST_CHAR_EOL) && w_ser_done;

    // A character finishing on this cycle behaves as IDLE so the next one starts with no gap.
    assign w_at_idle    = (r_state == ST_IDLE) ||
                          (w_ser_done && (((r_state == ST_CHAR_HI) && !w_ascii) ||
                                          (r_state == ST_CHAR_LO) || (r_state == ST_CHAR_EOL)));
    assign w_start_byte = w_at_idle && baud_lock && !w_fifo_empty;
    assign w_start_eol  = w_at_idle && baud_lock && w_fifo_empty && r_eol && !w_eol_clear;
    assign w_start_lo   = w_ascii && baud_lock &&
                          (((r_state == ST_CHAR_HI) && w_ser_done) ||
                           ((r_state == ST_CHAR_LO) && !r_ser_busy));
    assign w_pop        = w_start_byte;
    assign w_load       = w_start_byte || w_start_eol || w_start_lo;

    always_comb begin
        w_load_char = 8'h0A;
        if (w_start_byte)    w_load_char = w_ascii ? hex_char(w_fifo_q[7:4]) : w_fifo_q;
        else if (w_start_lo) w_load_char = hex_char(r_cur_lo);
    end

`ifdef MESA_TX_PARITY_EN
    assign w_frame_tail = {{STOP_BITS{1'b1}}, ^w_load_char, w_load_char};
`else
    assign w_frame_tail = {{STOP_BITS{1'b1}}, w_load_char};
`endif

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= byte_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
            r_level <= w_level_nxt;
            r_busy  <= (w_level_nxt == LVL_FULL);
            if (byte_en && r_busy) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_eol    <= 1'b0;
            r_cur_lo <= 4'h0;
        end else begin
            if (w_pop) r_cur_lo <= w_fifo_q[3:0];
            // A byte_done landing during the newline itself is absorbed by it.
            r_eol <= (r_eol || w_eol_set) && !w_eol_clear;
            if (w_start_byte)                             r_state <= ST_CHAR_HI;
            else if (w_start_eol)                         r_state <= ST_CHAR_EOL;
            else if (w_at_idle)                           r_state <= ST_IDLE;
            else if ((r_state == ST_CHAR_HI) && w_ser_done) r_state <= ST_CHAR_LO;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ser_busy  <= 1'b0;
            r_txd       <= 1'b1;
            r_shift     <= '0;
            r_bits_left <= 4'd0;
            r_baud_cnt  <= BAUD_ONE;
            r_baud_val  <= BAUD_ONE;
        end else if (w_load) begin
            r_ser_busy  <= 1'b1;
            r_txd       <= 1'b0;
            r_shift     <= w_frame_tail;
            r_bits_left <= SHIFT_CNT;
            r_baud_cnt  <= w_baud_eff;
            r_baud_val  <= w_baud_eff;
        end else if (r_ser_busy) begin
            if (r_baud_cnt == BAUD_ONE) begin
                if (r_bits_left == 4'd0) begin
                    r_ser_busy <= 1'b0;
                    r_txd      <= 1'b1;
                end else begin
                    r_txd       <= r_shift[0];
                    r_shift     <= r_shift >> 1;
                    r_bits_left <= r_bits_left - 4'd1;
                    r_baud_cnt  <= r_baud_val;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt - BAUD_ONE;
            end
        end
    end

    assign txd        = r_txd;
    assign byte_busy  = r_busy;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign tx_idle    = (r_state == ST_IDLE) && w_fifo_empty && !r_eol && !r_ser_busy;

endmodule

// File: tb/tb_mesa_uart_tx_fifo_phy.sv
// Directed bench: ASCII instance (baud 4, 1 stop) with a UART receiver, raw instance (baud 0, 2 stop).
module tb_mesa_uart_tx_fifo_phy;

  logic clk = 1'b0;
  logic rst;

  logic [15:0] a_baud;
  logic        a_lock, a_en, a_done, a_busy, a_txd, a_idle, a_ovf;
  logic [7:0]  a_d;
  logic [4:0]  a_level;

  logic [15:0] b_baud;
  logic        b_lock, b_en, b_done, b_busy, b_txd, b_idle, b_ovf;
  logic [7:0]  b_d;
  logic [4:0]  b_level;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] mon_ch;
  logic       mon_bad;

`ifdef MESA_TX_PARITY_EN
  localparam int FB = 12;
  localparam logic [31:0] F_A5 = 32'b010100101011;
  localparam logic [31:0] F_07 = 32'b011100000111;
  localparam logic [31:0] F_03 = 32'b011000000011;
`else
  localparam int FB = 11;
  localparam logic [31:0] F_A5 = 32'b01010010111;
  localparam logic [31:0] F_07 = 32'b01110000011;
  localparam logic [31:0] F_03 = 32'b01100000011;
`endif

  mesa_uart_tx_fifo_phy #(.FIFO_DEPTH_LOG2(4), .BAUD_W(16), .STOP_BITS(1), .ASCII_MODE(1)) dut_a (
    .clk(clk), .reset(rst), .baud_rate(a_baud), .baud_lock(a_lock),
    .byte_en(a_en), .byte_d(a_d), .byte_busy(a_busy), .byte_done(a_done),
    .txd(a_txd), .tx_idle(a_idle), .fifo_level(a_level), .overflow(a_ovf)
  );

  mesa_uart_tx_fifo_phy #(.FIFO_DEPTH_LOG2(4), .BAUD_W(16), .STOP_BITS(2), .ASCII_MODE(0)) dut_b (
    .clk(clk), .reset(rst), .baud_rate(b_baud), .baud_lock(b_lock),
    .byte_en(b_en), .byte_d(b_d), .byte_busy(b_busy), .byte_done(b_done),
    .txd(b_txd), .tx_idle(b_idle), .fifo_level(b_level), .overflow(b_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h61 + ({4'h0, n} - 8'd10);
  endfunction

  task automatic push_hex(input logic [7:0] b);
    exp_q.push_back(hex_ch(b[7:4]));
    exp_q.push_back(hex_ch(b[3:0]));
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rx_q.size() > 0)
      chk({tag, "_char"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    rx_q.delete();
  endtask

  // UART receiver for instance A (4 clocks per bit, sampled mid-bit)
  initial begin : mon_a
    forever begin
      @(negedge clk);
      if (!rst && a_txd == 1'b0) begin
        mon_bad = 1'b0;
        repeat (2) @(negedge clk);
        if (rst || a_txd) mon_bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          mon_ch[i] = a_txd;
          if (rst) mon_bad = 1'b1;
        end
        repeat (4) @(negedge clk);
        if (rst || !a_txd) mon_bad = 1'b1;
        if (!mon_bad) rx_q.push_back(mon_ch);
      end
    end
  end

  // drivers
  task automatic write_a(input logic [7:0] b);
    @(negedge clk); a_en = 1'b1; a_d = b;
    @(negedge clk); a_en = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] b);
    @(negedge clk); b_en = 1'b1; b_d = b;
    @(negedge clk); b_en = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag, input int max);
    int k;
    k = 0;
    while (!a_idle && k < max) begin @(negedge clk); k++; end
    chk(tag, 32'(a_idle), 1);
  endtask

  task automatic wait_start_a(input string tag, input int max);
    int k;
    k = 0;
    while (a_txd && k < max) begin @(negedge clk); k++; end
    chk(tag, 32'(a_txd), 0);
  endtask

  task automatic count_lows(input bit use_b, input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ((use_b ? b_txd : a_txd) == 1'b0) lows++;
    end
  endtask

  task automatic capture_b(input int n, output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      cap = {cap[30:0], b_txd};
      @(negedge clk);
    end
  endtask

  initial begin : main
    int k;
    int lows;
    logic [7:0] v;
    logic [31:0] cap;

    rst = 1'b1;
    a_baud = 16'd4; a_lock = 1'b1; a_en = 1'b0; a_d = 8'h00; a_done = 1'b0;
    b_baud = 16'd0; b_lock = 1'b1; b_en = 1'b0; b_d = 8'h00; b_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_txd", 32'(a_txd), 1);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_idle", 32'(a_idle), 1);
    chk("rst_level", 32'(a_level), 0);
    chk("rst_ovf", 32'(a_ovf), 0);

    // 0x5A -> '5','a', 80 clocks start-to-idle, no inter-char gap
    write_a(8'h5A);
    chk("a_level_after_wr", 32'(a_level), 1);
    chk("a_txd_before_pop", 32'(a_txd), 1);
    @(negedge clk);
    chk("a_start_bit", 32'(a_txd), 0);
    k = 0;
    while (!a_idle && k < 200) begin @(negedge clk); k++; end
    chk("a_5a_cycles", 32'(k), 80);
    exp_q.push_back(8'h35); exp_q.push_back(8'h61);
    check_rx("a_5a");

    // byte_done before a later byte: newline still last
    write_a(8'h01);
    @(negedge clk); a_done = 1'b1;
    @(negedge clk); a_done = 1'b0;
    write_a(8'hFF);
    wait_idle_a("a_eol_idle", 2000);
    push_hex(8'h01); push_hex(8'hFF); exp_q.push_back(8'h0A);
    check_rx("a_eol");

    // fill to full with lock low, overflow on 17th
    @(negedge clk); a_lock = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_en = 1'b1; v = 8'(i * 37 + 5); a_d = v;
      push_hex(v);
    end
    @(negedge clk);
    chk("a_full_level", 32'(a_level), 16);
    chk("a_full_busy", 32'(a_busy), 1);
    chk("a_full_ovf_before", 32'(a_ovf), 0);
    a_d = 8'hEE;
    @(negedge clk); a_en = 1'b0;
    chk("a_ovf_set", 32'(a_ovf), 1);
    chk("a_ovf_level", 32'(a_level), 16);
    chk("a_nolock_txd", 32'(a_txd), 1);
    chk("a_nolock_idle", 32'(a_idle), 0);
    a_lock = 1'b1;
    wait_idle_a("a_drain_idle", 3000);
    check_rx("a_drain");
    chk("a_ovf_sticky", 32'(a_ovf), 1);

    // lock dropped mid high char: low char waits
    write_a(8'h3C);
    wait_start_a("a_lock_start", 20);
    repeat (10) @(negedge clk);
    a_lock = 1'b0;
    repeat (100) @(negedge clk);
    exp_q.push_back(8'h33);
    check_rx("a_lockdrop");
    chk("a_hold_txd", 32'(a_txd), 1);
    chk("a_hold_idle", 32'(a_idle), 0);
    a_lock = 1'b1;
    wait_idle_a("a_resume_idle", 200);
    exp_q.push_back(8'h63);
    check_rx("a_resume");

    // asynchronous reset inside data bits
    write_a(8'h5A);
    write_a(8'h33);
    wait_start_a("a_rst_start", 20);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_txd", 32'(a_txd), 1);
    chk("midrst_level", 32'(a_level), 0);
    chk("midrst_ovf", 32'(a_ovf), 0);
    chk("midrst_idle", 32'(a_idle), 1);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    count_lows(1'b0, 200, lows);
    chk("post_rst_lows", 32'(lows), 0);
    check_rx("post_rst");

    // raw mode, 2 stop bits, baud 0 -> 1 clock per bit
    write_b(8'hA5);
    @(negedge clk);
    capture_b(FB, cap);
    chk("b_a5_frame", cap, F_A5);
    @(negedge clk); b_done = 1'b1;
    @(negedge clk); b_done = 1'b0;
    count_lows(1'b1, 50, lows);
    chk("b_done_lows", 32'(lows), 0);
    chk("b_done_idle", 32'(b_idle), 1);

    // back-to-back raw bytes: frames abut with no gap
    @(negedge clk); b_en = 1'b1; b_d = 8'h07;
    @(negedge clk); b_d = 8'h03;
    @(negedge clk); b_en = 1'b0;
    capture_b(2 * FB, cap);
    chk("b_b2b_frames", cap, (F_07 << FB) | F_03);
    repeat (3) @(negedge clk);
    chk("b_b2b_idle", 32'(b_idle), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesa_uart_tx_fifo_phy.md
Name: mesa_uart_tx_fifo_phy

Overview:
- Parametrised transmit PHY for the Mesa-Bus byte stream.
- Buffers binary bytes in a FIFO, optionally converts each byte to two lowercase ASCII hex characters, and serialises them as 8-N-1/8-N-2 UART frames.
- Bit timing comes from an externally supplied autobaud rate.
- Successor to the fixed byte-to-ASCII-plus-TX-UART pair on the Ro/Wo paths. Adds depth buffering, raw-binary mode, selectable stop bits and end-of-line insertion.

Parameters:
- FIFO_DEPTH_LOG2, 4, FIFO depth = 2**FIFO_DEPTH_LOG2 bytes (legal 1..8)
- BAUD_W, 16, width of baud_rate input
- STOP_BITS, 1, number of stop bits (1 or 2)
- ASCII_MODE, 1, 1 = each byte sent as two hex chars, high nibble first; 0 = raw byte

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- baud_rate  in  BAUD_W  clocks per UART bit (value 0 treated as 1)
- baud_lock  in  1  1 = baud_rate valid; transmission permitted
- byte_en  in  1  write strobe, one byte per asserted cycle
- byte_d  in  8  byte to transmit
- byte_busy  out  1  FIFO full; writes while high are dropped
- byte_done  in  1  pulse: request end-of-line after current data drains
- txd  out  1  serial output, idle high
- tx_idle  out  1  FIFO empty, no EOL pending, serialiser idle
- fifo_level  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy
- overflow  out  1  sticky: a write was dropped while full

Behaviour:
- Reset values (asynchronous, immediate, including mid-frame):
  - txd=1, byte_busy=0, tx_idle=1, fifo_level=0, overflow=0
  - FIFO pointers cleared, EOL-pending flag cleared, FSM in IDLE
- FIFO write:
  - Occurs on byte_en=1 and full=0.
  - byte_en=1 while full: no write, overflow set until reset.
- FIFO read: occurs when the FSM leaves IDLE to start a byte.
  - Simultaneous write and read: fifo_level unchanged.
  - Write to an empty FIFO is visible in fifo_level the next cycle.
  - Earliest read of that byte is the cycle after that.
- byte_busy = (fifo_level == 2**FIFO_DEPTH_LOG2), registered with fifo_level.
- Character FSM states: IDLE, CHAR_HI, CHAR_LO, CHAR_EOL.
  - IDLE -> CHAR_HI: baud_lock=1 and FIFO non-empty. Pops a byte.
  - IDLE -> CHAR_EOL: baud_lock=1, FIFO empty, EOL pending.
  - CHAR_HI -> CHAR_LO: ASCII_MODE=1 and serialiser finished the high char.
  - CHAR_HI -> IDLE: ASCII_MODE=0 and serialiser finished the raw byte.
  - CHAR_LO -> IDLE and CHAR_EOL -> IDLE: serialiser finished. CHAR_EOL also clears the EOL-pending flag.
- Hex mapping: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x61+(n-10).
- byte_done:
  - Sets EOL pending in ASCII_MODE=1; ignored in ASCII_MODE=0.
  - Newline 0x0A is sent only after the FIFO is empty. Bytes written after byte_done still precede the newline.
  - A byte_done arriving while EOL is already pending is merged.
- Serialiser:
  - Frame = start bit 0, d[0]..d[7] LSB first, then STOP_BITS bits of 1.
  - Each bit lasts exactly max(baud_rate,1) clocks, counted by a BAUD_W down-counter.
  - baud_rate is sampled at frame start; changes mid-frame take effect on the next frame.
  - txd is registered. The start bit appears 1 cycle after the FSM issues a character.
  - The next frame may start on the cycle after the final stop bit. There is no gap between back-to-back characters.
- baud_lock:
  - Dropping mid-frame: the current character completes, but the next character does not start.
  - In ASCII_MODE, a byte whose high char has been sent holds in CHAR_LO until baud_lock returns.
- tx_idle = IDLE and FIFO empty and no EOL pending and serialiser idle.

Optional Feature:
- Macro MESA_TX_PARITY_EN.
  - Defined: an even-parity bit (XOR of d[7:0]) is inserted between d[7] and the first stop bit. Frame becomes 11 or 12 bits.
  - Undefined: no parity bit; frame is 10 or 11 bits.
- FIFO, FSM and EOL behaviour are identical in both builds.

Test Plan:
- Reset, baud_rate=4, baud_lock=1, ASCII_MODE=1, write 0x5A: txd sends '5' (0x35) then 'a' (0x61). Each bit is 4 clocks, 80 clocks total. tx_idle returns to 1 after the final stop bit.
- Write 0x01, pulse byte_done, then write 0xFF before the first char ends: sequence is "01ff\n" (0x30,0x31,0x66,0x66,0x0A), with the newline last.
- Depth 16, baud_lock=0, write 17 bytes: byte_busy=1 after 16, 17th dropped, overflow=1, fifo_level=16, txd stays 1. Raise baud_lock: all 16 bytes transmitted in order.
- ASCII_MODE=0, STOP_BITS=2, baud_rate=0, write 0xA5: txd = 0,1,0,1,0,0,1,0,1,1,1 at 1 clock per bit. byte_done produces no output.
- Assert reset mid-way through the data bits of a frame: txd=1 immediately. fifo_level=0 and overflow=0. No residual character is sent after reset release.
- MESA_TX_PARITY_EN defined, write raw 0x07: parity bit = 1 after d[7], then stop. With 0x03: parity bit = 0.
